instr_fetch_unit: RTL and testbench

Instruction fetch stage of the RV32 pipeline: the requesting end of the instruction-memory read interface. It holds the PC, presents a word address to the combinational instruction memory every cycle and captures the returned word with its PC in a small FIFO. The FIFO feeds decode through a valid/ready handshake. A redirect from branch/jump resolution flushes the FIFO and restarts fetch at the target.

---
 rtl/instr_fetch_unit.sv | 85 ++++++++
 tb/tb_instr_fetch_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RV32 fetch stage: PC, imem request, instruction buffer toward decode
// Redirect flushes the buffer and restarts fetch at the target.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      buf_pc_q    [DEPTH];
    logic [31:0]      buf_instr_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, pop;

    assign imem_addr_o = pc_q;
    assign id_valid_o  = (count_q != '0) & ~redirect_valid_i;
    assign id_instr_o  = buf_instr_q[rd_ptr_q];
    assign id_pc_o     = buf_pc_q[rd_ptr_q];

    assign pop  = id_valid_o & id_ready_i;
    assign push = ~redirect_valid_i & ((count_q != FULL) | pop);

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid_i) begin
            // Masking keeps the whole target bus in use; low bits are forced to zero.
            pc_d     = redirect_pc_i & 32'hFFFF_FFFC;
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_pc_q[i]    <= 32'h0;
                buf_instr_q[i] <= NOP;
            end
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push) begin
                buf_pc_q[wr_ptr_q]    <= pc_q;
                buf_instr_q[wr_ptr_q] <= imem_instr_i;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed bench for instr_fetch_unit (main DUT plus wrap-around instance)
module tb_instr_fetch_unit;
    logic        clk;
    logic        rst_n;
    logic [31:0] addr_a, instr_a, rpc_a, iinstr_a, ipc_a;
    logic        redir_a, valid_a, ready_a;
    logic [31:0] addr_b, instr_b, iinstr_b, ipc_b;
    logic        valid_b;
    logic        redir_b;
    logic        ready_b;
    logic [31:0] rpc_b;
    int          total;
    int          bad;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00a0_0093;
        if (a == 32'h4) return 32'h0050_8113;
        return {a[31:2], 2'b11} ^ 32'h5A00_0000;
    endfunction

    assign instr_a = imem_word(addr_a);
    assign instr_b = imem_word(addr_b);

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .imem_addr_o(addr_a), .imem_instr_i(instr_a),
        .redirect_valid_i(redir_a), .redirect_pc_i(rpc_a), .id_valid_o(valid_a),
        .id_ready_i(ready_a), .id_instr_o(iinstr_a), .id_pc_o(ipc_a)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
        .clk_i(clk), .rst_ni(rst_n), .imem_addr_o(addr_b), .imem_instr_i(instr_b),
        .redirect_valid_i(redir_b), .redirect_pc_i(rpc_b), .id_valid_o(valid_b),
        .id_ready_i(ready_b), .id_instr_o(iinstr_b), .id_pc_o(ipc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic [31:0] ad);
        chk({tag, "_valid"}, {31'h0, valid_a}, {31'h0, v});
        if (v) begin
            chk({tag, "_pc"}, ipc_a, pc);
            chk({tag, "_instr"}, iinstr_a, ins);
        end
        chk({tag, "_addr"}, addr_a, ad);
    endtask

    task automatic chk_b(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] ad);
        chk({tag, "_valid"}, {31'h0, valid_b}, 32'h1);
        chk({tag, "_pc"}, ipc_b, pc);
        chk({tag, "_instr"}, iinstr_b, ins);
        chk({tag, "_addr"}, addr_b, ad);
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; redir_a = 1'b0; rpc_a = 32'h0; ready_a = 1'b1;
        redir_b = 1'b0; rpc_b = 32'h0; ready_b = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_addr", addr_a, 32'h0);
        chk("rst_valid", {31'h0, valid_a}, 32'h0);
        chk("rst_instr", iinstr_a, 32'h0000_0013);
        chk("rst_pc", ipc_a, 32'h0);
        chk("rst_wrap_addr", addr_b, 32'hFFFF_FFF8);

        // Startup: first fetch right after release, decode sees it one edge later
        rst_n = 1'b1;
        #1;
        chk_a("start0", 1'b0, 32'h0, 32'h0, 32'h0);
        chk("start0_wrap_valid", {31'h0, valid_b}, 32'h0);
        @(negedge clk);
        chk_a("start1", 1'b1, 32'h0, 32'h00a0_0093, 32'h4);
        chk_b("wrap1", 32'hFFFF_FFF8, 32'hA5FF_FFFB, 32'hFFFF_FFFC);
        @(negedge clk);
        chk_a("start2", 1'b1, 32'h4, 32'h0050_8113, 32'h8);
        chk_b("wrap2", 32'hFFFF_FFFC, 32'hA5FF_FFFF, 32'h0);
        @(negedge clk);
        chk_a("start3", 1'b1, 32'h8, 32'h5A00_000B, 32'hC);
        chk_b("wrap3", 32'h0, 32'h00a0_0093, 32'h4);
        @(negedge clk);
        chk_a("start4", 1'b1, 32'hC, 32'h5A00_000F, 32'h10);
        chk_b("wrap4", 32'h4, 32'h0050_8113, 32'h8);

        // Stall: buffer fills, PC freezes
        ready_a = 1'b0;
        repeat (5) @(negedge clk);
        chk_a("stall", 1'b1, 32'hC, 32'h5A00_000F, 32'h14);

        // Resume: back-to-back stream, full buffer with simultaneous pop keeps pushing
        ready_a = 1'b1;
        @(negedge clk);
        chk_a("resume1", 1'b1, 32'h10, 32'h5A00_0013, 32'h18);
        @(negedge clk);
        chk_a("resume2", 1'b1, 32'h14, 32'h5A00_0017, 32'h1C);
        @(negedge clk);
        chk_a("resume3", 1'b1, 32'h18, 32'h5A00_001B, 32'h20);

        // Full: single-cycle pop pushes one, stays full
        ready_a = 1'b0;
        @(negedge clk);
        chk_a("full_hold", 1'b1, 32'h18, 32'h5A00_001B, 32'h20);
        ready_a = 1'b1;
        @(negedge clk);
        chk_a("full_pop", 1'b1, 32'h1C, 32'h5A00_001F, 32'h24);
        ready_a = 1'b0;
        @(negedge clk);
        chk_a("full_again", 1'b1, 32'h1C, 32'h5A00_001F, 32'h24);

        // Redirect with two buffered entries; low target bits dropped
        ready_a = 1'b1; redir_a = 1'b1; rpc_a = 32'h0000_0026;
        #1;
        chk("redir_valid_same", {31'h0, valid_a}, 32'h0);
        @(negedge clk);
        redir_a = 1'b0; rpc_a = 32'h0;
        #1;
        chk_a("redir1", 1'b0, 32'h0, 32'h0, 32'h24);
        @(negedge clk);
        chk_a("redir2", 1'b1, 32'h24, 32'h5A00_0027, 32'h28);
        @(negedge clk);
        chk_a("redir3", 1'b1, 32'h28, 32'h5A00_002B, 32'h2C);

        // Asynchronous reset between edges with a full buffer
        ready_a = 1'b0;
        @(negedge clk);
        chk_a("pre_arst", 1'b1, 32'h28, 32'h5A00_002B, 32'h30);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'h0, valid_a}, 32'h0);
        chk("arst_addr", addr_a, 32'h0);
        chk("arst_instr", iinstr_a, 32'h0000_0013);
        chk("arst_pc", ipc_a, 32'h0);
        chk("arst_wrap_addr", addr_b, 32'hFFFF_FFF8);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_a("restart", 1'b1, 32'h0, 32'h00a0_0093, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
